// File: rtl/shared_block_memory.sv
// Block-oriented main memory shared by an instruction-cache port (P0) and a data-cache port (P1).
// Busywait handshake, fixed access latency, round-robin arbitration on simultaneous requests.
module shared_block_memory #(
  parameter int unsigned BLOCK_WIDTH    = 128,
  parameter int unsigned ADDR_WIDTH     = 28,
  parameter int unsigned DEPTH_LOG2     = 8,
  parameter int unsigned LATENCY        = 5,
  parameter int unsigned CLEAR_ON_RESET = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   P0_READ,
  input  logic                   P0_WRITE,
  input  logic [ADDR_WIDTH-1:0]  P0_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0] P0_WRITEDATA,
  output logic [BLOCK_WIDTH-1:0] P0_READDATA,
  output logic                   P0_BUSYWAIT,
  input  logic                   P1_READ,
  input  logic                   P1_WRITE,
  input  logic [ADDR_WIDTH-1:0]  P1_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0] P1_WRITEDATA,
  output logic [BLOCK_WIDTH-1:0] P1_READDATA,
  output logic                   P1_BUSYWAIT
);

  localparam int unsigned NUM_BLOCKS = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("shared_block_memory: LATENCY must be at least 1");
    end
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > ADDR_WIDTH) begin : g_bad_depth
      $error("shared_block_memory: DEPTH_LOG2 must lie in 1..ADDR_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state, next_state;
  logic                   req0, req1;
  logic                   start, arb_grant, do_access;
  logic                   grant, last_grant, op_write;
  logic [DEPTH_LOG2-1:0]  idx;
  logic [BLOCK_WIDTH-1:0] wdata;
  logic [CNT_W-1:0]       count;
  logic [BLOCK_WIDTH-1:0] mem [NUM_BLOCKS];

  // Upper address bits alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{P0_ADDRESS, P1_ADDRESS};

  assign req0 = P0_READ | P0_WRITE;
  assign req1 = P1_READ | P1_WRITE;

  assign P0_BUSYWAIT = req0 & ~((state == DONE) & (grant == 1'b0));
  assign P1_BUSYWAIT = req1 & ~((state == DONE) & (grant == 1'b1));

  assign do_access = (state == BUSY) && (count == '0);

  always_comb begin
    next_state = state;
    start      = 1'b0;
    arb_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          start      = 1'b1;
          next_state = BUSY;
          if (req0 && req1) arb_grant = ~last_grant;
          else              arb_grant = req1;
        end
      end
      BUSY: begin
        if (count == '0) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_write   <= 1'b0;
      idx        <= '0;
      wdata      <= '0;
      count      <= '0;
    end else begin
      if (start) begin
        grant    <= arb_grant;
        op_write <= arb_grant ? P1_WRITE : P0_WRITE;
        idx      <= arb_grant ? P1_ADDRESS[DEPTH_LOG2-1:0] : P0_ADDRESS[DEPTH_LOG2-1:0];
        wdata    <= arb_grant ? P1_WRITEDATA : P0_WRITEDATA;
        count    <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY && count != '0) begin
        count <= count - 1'b1;
      end
      if (state == DONE) last_grant <= grant;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      P0_READDATA <= '0;
      P1_READDATA <= '0;
    end else if (do_access && !op_write) begin
      if (grant) P1_READDATA <= mem[idx];
      else       P0_READDATA <= mem[idx];
    end
  end

  // Array only has a reset path when clearing is requested, so preloaded images survive otherwise.
  generate
    if (CLEAR_ON_RESET != 0) begin : g_clear
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          for (int unsigned i = 0; i < NUM_BLOCKS; i++) mem[i] <= '0;
        end else if (do_access && op_write) begin
          mem[idx] <= wdata;
        end
      end
    end else begin : g_keep
      always_ff @(posedge CLK) begin
        if (do_access && op_write) mem[idx] <= wdata;
      end
    end
  endgenerate

endmodule
